// File: rtl/logic_op_pkg.sv
// Shared definitions for the bit-serial logic sequencer: logic-unit op codes
// and the controller state encoding.
package logic_op_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_logic_sequencer_if.sv
// Command/response port of the bit-serial logic sequencer.
// The master issues commands and consumes results; the slave is the sequencer.
interface bit_serial_logic_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/bit_serial_logic_sequencer.sv
// Drives an external 1-bit logic unit one operand bit per cycle, LSB first,
// and assembles its output bits into a WIDTH-bit response word.
//
// state | meaning
// IDLE  | ready for a command; logic-unit inputs parked at 0
// SHIFT | presenting operand bits to the logic unit, capturing one result bit per edge
// DONE  | result word offered on the response port until taken
module bit_serial_logic_sequencer
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bit_serial_logic_sequencer_if.slave   bus,
  output logic                          lu_a,
  output logic                          lu_b,
  output logic [2:0]                    lu_sel,
  input  logic                          lu_s,
  output logic                          busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    count;
  logic             cmd_ready_q;
  logic             rsp_valid_q;

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = result;

  // a_q/b_q hold the bits not yet presented; lu_a/lu_b hold the bit on the wire now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result      <= '0;
      count       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy        <= 1'b0;
      lu_a        <= 1'b0;
      lu_b        <= 1'b0;
      lu_sel      <= OP_NOTA;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            a_q         <= bus.cmd_a >> 1;
            b_q         <= bus.cmd_b >> 1;
            lu_a        <= bus.cmd_a[0];
            lu_b        <= bus.cmd_b[0];
            lu_sel      <= bus.cmd_op;
            count       <= '0;
            cmd_ready_q <= 1'b0;
            busy        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          result <= {lu_s, result[WIDTH-1:1]};
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            lu_a        <= 1'b0;
            lu_b        <= 1'b0;
            lu_sel      <= OP_NOTA;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            lu_a <= a_q[0];
            lu_b <= b_q[0];
          end
        end
        DONE: begin
          // Returning through IDLE keeps a new accept out of the handshake cycle.
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
